// File: rtl/pattern_ram_arbiter.sv
// Arbiter for the single-port pattern RAM: scan-out reads always win, HPS ioctl
// download writes are queued in a small FIFO and committed on idle RAM cycles.
module pattern_ram_arbiter #(
  parameter int unsigned AW         = 17,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_LIMIT = 76800
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_data,
  output logic          ioctl_wait,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          load_busy,
  output logic          load_done,
  output logic          overflow,
  output logic [AW-1:0] wr_count
);

  localparam int unsigned    PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]  LIMIT    = AW'(ADDR_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_dl_d;
  logic            w_rise;
  logic            w_fall;
  logic            w_enter_load;
  logic            w_load_done;

  logic [AW-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DW-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            w_empty;
  logic            w_full;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;

  logic [AW-1:0]   r_last_addr;
  logic [AW-1:0]   w_ram_addr;
  logic            w_ram_we;
  logic [DW-1:0]   w_ram_wdata;
  logic            r_rd_pend;
  logic            r_vid_valid;
  logic [DW-1:0]   r_vid_data;
  logic            r_overflow;
  logic [AW-1:0]   r_wr_count;

  assign w_rise     = ioctl_download & ~r_dl_d;
  assign w_fall     = ~ioctl_download & r_dl_d;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = ~vid_req & ~w_empty;
  assign w_push_req = (r_state == ST_LOAD) & ioctl_wr & (ioctl_addr < LIMIT);
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_dl_d  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_dl_d  <= ioctl_download;
    end
  end

  // Leaving DRAIN checks the download level: it can only be high there after a
  // new rising edge, which is held until the queue has emptied.
  always_comb begin
    w_next_state = r_state;
    w_enter_load = 1'b0;
    w_load_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_next_state = ST_LOAD;
          w_enter_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_fall) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_empty) begin
          if (ioctl_download) begin
            w_next_state = ST_LOAD;
            w_enter_load = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
            w_load_done  = 1'b1;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= ioctl_addr;
      r_fifo_data[r_wr_ptr] <= ioctl_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_ram_addr  = r_last_addr;
    w_ram_we    = 1'b0;
    w_ram_wdata = '0;
    if (vid_req) begin
      w_ram_addr = vid_addr;
    end else if (w_pop) begin
      w_ram_addr  = r_fifo_addr[r_rd_ptr];
      w_ram_wdata = r_fifo_data[r_rd_ptr];
      w_ram_we    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_addr <= '0;
      r_rd_pend   <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      if (vid_req | w_pop) r_last_addr <= w_ram_addr;
      r_rd_pend   <= vid_req;
      r_vid_valid <= r_rd_pend;
      if (r_rd_pend) r_vid_data <= ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_wr_count <= '0;
    end else begin
      if (w_enter_load)  r_overflow <= 1'b0;
      else if (w_drop)   r_overflow <= 1'b1;
      if (w_enter_load)                    r_wr_count <= '0;
      else if (w_pop && r_wr_count != '1)  r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign ioctl_wait = w_full;
  assign vid_data   = r_vid_data;
  assign vid_valid  = r_vid_valid;
  assign ram_addr   = w_ram_addr;
  assign ram_we     = w_ram_we;
  assign ram_wdata  = w_ram_wdata;
  assign load_busy  = (r_state != ST_IDLE);
  assign load_done  = w_load_done;
  assign overflow   = r_overflow;
  assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_pattern_ram_arbiter.sv
// Directed bench for pattern_ram_arbiter with a behavioural synchronous RAM
// and a log of every committed RAM write.
module tb_pattern_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic        vid_req;
  logic [16:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        load_busy;
  logic        load_done;
  logic        overflow;
  logic [16:0] wr_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  logic [24:0] wlog[$];
  logic [7:0]  mem [0:131071];

  always #5 clk = ~clk;

  pattern_ram_arbiter #(
    .AW(17), .DW(8), .FIFO_DEPTH(4), .ADDR_LIMIT(76800)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .load_busy(load_busy), .load_done(load_done), .overflow(overflow), .wr_count(wr_count)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wlog.push_back({ram_addr, ram_wdata});
    end
    ram_rdata <= mem[ram_addr];
    if (load_done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [16:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wr_wait(input logic [16:0] a, input logic [7:0] d);
    int k = 0;
    while (ioctl_wait && k < 50) begin
      tick();
      k++;
    end
    check("wait_release", ioctl_wait, 0);
    wr(a, d);
  endtask

  task automatic start_load();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_load();
    int k = 0;
    ioctl_download = 1'b0;
    while (load_busy && k < 50) begin
      tick();
      k++;
    end
    check("drain_end", load_busy, 0);
    tick();
  endtask

  task automatic clear_log();
    wlog.delete();
    n_done = 0;
  endtask

  function automatic logic [24:0] log_at(input int i);
    return (i < wlog.size()) ? wlog[i] : '1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    vid_req        = 1'b0;
    vid_addr       = '0;
    repeat (3) tick();
    check("rst_ctrl", {ioctl_wait, vid_valid, ram_we, load_busy, load_done, overflow}, 0);
    check("rst_vid_data", vid_data, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_wr_count", wr_count, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // strobe outside a download
    wr(17'd3, 8'h77);
    repeat (2) tick();
    check("idle_wr_ignored", wlog.size(), 0);
    check("idle_no_overflow", overflow, 0);

    // plain 8-byte load
    start_load();
    check("a_busy", load_busy, 1);
    for (int i = 0; i < 8; i++) wr(17'(i), 8'hA0 + 8'(i));
    end_load();
    check("a_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8; i++) check("a_write", log_at(i), {17'(i), 8'hA0 + 8'(i)});
    check("a_done", n_done, 1);
    check("a_wr_count", wr_count, 8);
    check("a_overflow", overflow, 0);
    clear_log();

    // async reset with 3 entries queued
    start_load();
    vid_req  = 1'b1;
    vid_addr = 17'd100;
    for (int i = 0; i < 3; i++) wr(17'h40 + 17'(i), 8'h90 + 8'(i));
    check("r_busy", load_busy, 1);
    check("r_wait", ioctl_wait, 0);
    reset_n        = 1'b0;
    vid_req        = 1'b0;
    vid_addr       = '0;
    ioctl_download = 1'b0;
    #1;
    check("r_async_ctrl", {ioctl_wait, vid_valid, ram_we, load_busy, load_done, overflow}, 0);
    check("r_async_addr", ram_addr, 0);
    check("r_async_count", wr_count, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check("r_no_writes", wlog.size(), 0);
    check("r_no_done", n_done, 0);
    check("r_idle", load_busy, 0);
    clear_log();

    // video starves writes, HPS honours ioctl_wait
    start_load();
    vid_req  = 1'b1;
    vid_addr = 17'd200;
    for (int i = 0; i < 4; i++) begin
      wr(17'h10 + 17'(i), 8'h50 + 8'(i));
      check("c_wait", ioctl_wait, (i == 3) ? 1 : 0);
    end
    repeat (6) tick();
    check("c_wait_hold", ioctl_wait, 1);
    check("c_starved", wlog.size(), 0);
    vid_req = 1'b0;
    wr_wait(17'h14, 8'h54);
    wr_wait(17'h15, 8'h55);
    end_load();
    check("c_nwrites", wlog.size(), 6);
    for (int i = 0; i < 6; i++) check("c_write", log_at(i), {17'h10 + 17'(i), 8'h50 + 8'(i)});
    check("c_overflow", overflow, 0);
    check("c_wr_count", wr_count, 6);
    check("c_done", n_done, 1);
    clear_log();

    // 5th byte into a full FIFO while video holds the port
    start_load();
    vid_req = 1'b1;
    for (int i = 0; i < 5; i++) wr(17'h20 + 17'(i), 8'h60 + 8'(i));
    check("d_overflow", overflow, 1);
    check("d_wait", ioctl_wait, 1);
    vid_req = 1'b0;
    end_load();
    check("d_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4; i++) check("d_write", log_at(i), {17'h20 + 17'(i), 8'h60 + 8'(i)});
    check("d_wr_count", wr_count, 4);
    check("d_overflow_sticky", overflow, 1);
    start_load();
    check("d_overflow_cleared", overflow, 0);
    check("d_count_cleared", wr_count, 0);
    end_load();
    clear_log();

    // address limit
    start_load();
    wr(17'd76800, 8'h11);
    wr(17'd76799, 8'h22);
    end_load();
    check("e_nwrites", wlog.size(), 1);
    check("e_write", log_at(0), {17'd76799, 8'h22});
    check("e_wr_count", wr_count, 1);
    check("e_overflow", overflow, 0);
    clear_log();

    // read-back latency
    start_load();
    wr(17'd5, 8'h3C);
    end_load();
    vid_req  = 1'b1;
    vid_addr = 17'd5;
    #1;
    check("f_ram_addr", ram_addr, 5);
    check("f_ram_we", ram_we, 0);
    tick();
    vid_req  = 1'b0;
    vid_addr = '0;
    check("f_valid_n1", vid_valid, 0);
    tick();
    check("f_valid_n2", vid_valid, 1);
    check("f_data", vid_data, 8'h3C);
    tick();
    check("f_valid_n3", vid_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
